// File: rtl/interp_dim_sequencer.sv
// Two-pass (horizontal then vertical) row sequencer for separable fractional interpolation.
// Optional build macro INTERP_SKIP_ZERO_FRAC_EN: skip a pass whose captured MV fraction is zero.
module interp_dim_sequencer #(
    parameter int BLOCK_H = 8,
    parameter int TAPS    = 8,
    parameter int CNT_W   = 5
) (
    input  logic                    CLK,
    input  logic                    RST,
    input  logic                    START,
    input  logic signed [3:0]       MV_X_FRAC,
    input  logic signed [3:0]       MV_Y_FRAC,
    input  logic                    STALL,
    output logic                    READY,
    output logic                    SEL_DIM,
    output logic                    FILTER_EN,
    output logic [CNT_W-1:0]        ROW_CNT,
    output logic                    LAST_ROW,
    output logic                    DONE
);

`ifdef INTERP_SKIP_ZERO_FRAC_EN
    localparam bit SKIP_EN = 1'b1;
`else
    localparam bit SKIP_EN = 1'b0;
`endif

    // Index of the final row: the horizontal pass carries TAPS-1 extra rows to feed the vertical taps.
    localparam logic [CNT_W-1:0] LAST_LONG  = CNT_W'(BLOCK_H + TAPS - 2);
    localparam logic [CNT_W-1:0] LAST_SHORT = CNT_W'(BLOCK_H - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_HOR  = 2'd1,
        S_VER  = 2'd2,
        S_FIN  = 2'd3
    } state_t;

    state_t                 state_q, state_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic signed [3:0]      fx_q, fx_d;
    logic signed [3:0]      fy_q, fy_d;

    logic                   skip_x_in;
    logic                   skip_y_in;
    logic                   skip_ver;
    logic                   active;
    logic [CNT_W-1:0]       last_idx;

    always_comb begin
        skip_x_in = SKIP_EN && (MV_X_FRAC == 4'sd0);
        skip_y_in = SKIP_EN && (MV_Y_FRAC == 4'sd0);
        skip_ver  = SKIP_EN && (fy_q == 4'sd0);

        last_idx = LAST_SHORT;
        if (state_q == S_HOR && !skip_ver) begin
            last_idx = LAST_LONG;
        end

        state_d = state_q;
        cnt_d   = cnt_q;
        fx_d    = fx_q;
        fy_d    = fy_q;

        case (state_q)
            S_IDLE: begin
                cnt_d = '0;
                if (START) begin
                    fx_d = MV_X_FRAC;
                    fy_d = MV_Y_FRAC;
                    if (skip_x_in && skip_y_in) begin
                        state_d = S_FIN;
                    end else if (skip_x_in) begin
                        state_d = S_VER;
                    end else begin
                        state_d = S_HOR;
                    end
                end
            end
            S_HOR: begin
                if (!STALL) begin
                    if (cnt_q == last_idx) begin
                        cnt_d   = '0;
                        state_d = skip_ver ? S_FIN : S_VER;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end
            S_VER: begin
                if (!STALL) begin
                    if (cnt_q == last_idx) begin
                        cnt_d   = '0;
                        state_d = S_FIN;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            fx_q    <= '0;
            fy_q    <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            fx_q    <= fx_d;
            fy_q    <= fy_d;
        end
    end

    // Everything decodes registered state; only the row strobes see STALL directly.
    always_comb begin
        active    = (state_q == S_HOR) || (state_q == S_VER);
        READY     = (state_q == S_IDLE);
        SEL_DIM   = (state_q == S_HOR);
        DONE      = (state_q == S_FIN);
        ROW_CNT   = cnt_q;
        FILTER_EN = active && !STALL;
        LAST_ROW  = active && !STALL && (cnt_q == last_idx);
    end

endmodule

// File: tb/tb_interp_dim_sequencer.sv
// Table-driven bench for interp_dim_sequencer: per-cycle input/expected-output vectors.
module tb_interp_dim_sequencer;

    localparam int CNT_W = 5;

    logic              CLK = 1'b0;
    logic              RST;
    logic              START;
    logic signed [3:0] MV_X_FRAC;
    logic signed [3:0] MV_Y_FRAC;
    logic              STALL;
    logic              READY;
    logic              SEL_DIM;
    logic              FILTER_EN;
    logic [CNT_W-1:0]  ROW_CNT;
    logic              LAST_ROW;
    logic              DONE;

    interp_dim_sequencer #(.BLOCK_H(8), .TAPS(8), .CNT_W(CNT_W)) dut (
        .CLK       (CLK),
        .RST       (RST),
        .START     (START),
        .MV_X_FRAC (MV_X_FRAC),
        .MV_Y_FRAC (MV_Y_FRAC),
        .STALL     (STALL),
        .READY     (READY),
        .SEL_DIM   (SEL_DIM),
        .FILTER_EN (FILTER_EN),
        .ROW_CNT   (ROW_CNT),
        .LAST_ROW  (LAST_ROW),
        .DONE      (DONE)
    );

    always #5 CLK = ~CLK;

    int errors = 0;
    int checks = 0;

    // Expected output word: {READY, SEL_DIM, FILTER_EN, ROW_CNT[4:0], LAST_ROW, DONE}
    typedef struct {
        logic       rst;
        logic       start;
        logic       stall;
        logic [3:0] x;
        logic [3:0] y;
        logic [9:0] exp;
    } vec_t;

    vec_t tab[64];

    localparam logic [9:0] IDLE_EXP = 10'b1_0_0_00000_0_0;

    function automatic logic [9:0] ex(input bit r, input bit s, input bit f,
                                      input int c, input bit l, input bit d);
        logic [4:0] c5;
        c5 = 5'(c);
        return {r, s, f, c5, l, d};
    endfunction

    task automatic clear_tab();
        for (int i = 0; i < 64; i++) begin
            tab[i] = '{1'b0, 1'b0, 1'b0, 4'd0, 4'd0, IDLE_EXP};
        end
    endtask

    // Full two-pass block started at cycle c0; optional stall of stall_len cycles at HOR row 6.
    task automatic put_block(input int c0, input logic [3:0] x, input logic [3:0] y,
                             input int stall_len, output int c_end);
        int c;
        tab[c0].start = 1'b1;
        tab[c0].x     = x;
        tab[c0].y     = y;
        c = c0 + 1;
        for (int r = 0; r < 15; r++) begin
            if (r == 6) begin
                for (int k = 0; k < stall_len; k++) begin
                    tab[c].stall = 1'b1;
                    tab[c].exp   = ex(0, 1, 0, 6, 0, 0);
                    c++;
                end
            end
            tab[c].exp = ex(0, 1, 1, r, r == 14, 0);
            c++;
        end
        for (int r = 0; r < 8; r++) begin
            tab[c].exp = ex(0, 0, 1, r, r == 7, 0);
            c++;
        end
        tab[c].exp = ex(0, 0, 0, 0, 0, 1);
        c++;
        c_end = c;
    endtask

    task automatic run(input string name, input int n);
        logic [9:0] got;
        for (int i = 0; i < n; i++) begin
            RST       = tab[i].rst;
            START     = tab[i].start;
            STALL     = tab[i].stall;
            MV_X_FRAC = tab[i].x;
            MV_Y_FRAC = tab[i].y;
            #1;
            got = {READY, SEL_DIM, FILTER_EN, ROW_CNT, LAST_ROW, DONE};
            checks++;
            if (got !== tab[i].exp) begin
                errors++;
                $display("FAIL %s cycle %0d: got %b required %b (rdy sel fen cnt last done)",
                         name, i, got, tab[i].exp);
            end
            @(posedge CLK);
            #1;
        end
        RST = 1'b0; START = 1'b0; STALL = 1'b0; MV_X_FRAC = 4'sd0; MV_Y_FRAC = 4'sd0;
        // Drain two cycles so every scenario starts from IDLE.
        @(posedge CLK); #1;
        @(posedge CLK); #1;
    endtask

    initial begin
        int e;
        RST = 1'b1; START = 1'b0; STALL = 1'b0; MV_X_FRAC = 4'sd0; MV_Y_FRAC = 4'sd0;
        @(posedge CLK); #1;
        START = 1'b1; STALL = 1'b1; MV_X_FRAC = 4'sd3; MV_Y_FRAC = 4'sd5;
        @(posedge CLK); #1;
        RST = 1'b0; START = 1'b0; STALL = 1'b0;
        #1;
        checks++;
        if ({READY, SEL_DIM, FILTER_EN, ROW_CNT, LAST_ROW, DONE} !== IDLE_EXP) begin
            errors++;
            $display("FAIL reset_state: got %b required %b",
                     {READY, SEL_DIM, FILTER_EN, ROW_CNT, LAST_ROW, DONE}, IDLE_EXP);
        end
        @(posedge CLK); #1;

        // Basic block X=3, Y=5: HOR 1-15, VER 16-23, DONE 24, READY 25.
        clear_tab();
        put_block(0, 4'd3, 4'd5, 0, e);
        run("basic", e + 2);

        // Three stall cycles at HOR row 6, plus a stall during FIN that must not hold it.
        clear_tab();
        put_block(0, 4'd3, 4'd5, 3, e);
        tab[e - 1].stall = 1'b1;
        run("stall", e + 2);

        // Second START during HOR is ignored; idle tail proves no second DONE.
        clear_tab();
        put_block(0, 4'd3, 4'd5, 0, e);
        tab[10].start = 1'b1;
        tab[10].x     = 4'd1;
        tab[10].y     = 4'd1;
        run("restart_ignored", 34);

        // Reset at cycle 18 during VER aborts the block; fresh START at 20 runs a full block.
        clear_tab();
        put_block(0, 4'd3, 4'd5, 0, e);
        for (int i = 19; i < 64; i++) begin
            tab[i] = '{1'b0, 1'b0, 1'b0, 4'd0, 4'd0, IDLE_EXP};
        end
        tab[18].rst = 1'b1;
        put_block(20, 4'd7, 4'd2, 0, e);
        run("reset_mid_ver", e + 2);

`ifdef INTERP_SKIP_ZERO_FRAC_EN
        // X=0, Y=-4: vertical pass only.
        clear_tab();
        tab[0].start = 1'b1; tab[0].x = 4'd0; tab[0].y = 4'b1100;
        for (int r = 0; r < 8; r++) tab[1 + r].exp = ex(0, 0, 1, r, r == 7, 0);
        tab[9].exp = ex(0, 0, 0, 0, 0, 1);
        run("skip_hor", 11);

        // X=-2, Y=0: horizontal pass only, 8 rows.
        clear_tab();
        tab[0].start = 1'b1; tab[0].x = 4'b1110; tab[0].y = 4'd0;
        for (int r = 0; r < 8; r++) tab[1 + r].exp = ex(0, 1, 1, r, r == 7, 0);
        tab[9].exp = ex(0, 0, 0, 0, 0, 1);
        run("skip_ver", 11);

        // Both zero: DONE straight after START.
        clear_tab();
        tab[0].start = 1'b1;
        tab[1].exp = ex(0, 0, 0, 0, 0, 1);
        run("skip_both", 4);
`else
        // Zero fractions still run both full passes.
        clear_tab();
        put_block(0, 4'd0, 4'd0, 0, e);
        run("zero_frac_full", e + 2);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
